debug_dump_uart: RTL and testbench
==================================

DEBUG_DUMP_UART -- requirements
Module: debug_dump_uart

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, named clk and rst_n.
REQ-002 Parameter CLKS_PER_BIT, default 868, SHALL set the UART bit period in clk cycles (minimum 4).
REQ-003 Parameter SETTLE_CYCLES, default 2, SHALL set the cycles held after an address change before read_data is sampled (minimum 1).
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 stopped  input  1  CPU halted flag from the CPU top level.
REQ-007 dump_req  input  1  manual dump trigger, level, synchronous to clk.
REQ-008 read_data  input  8  debug data returned for the current read_addr/is_dm_access.
REQ-009 read_addr  output  4  debug read address driven to the CPU top level.
REQ-010 is_dm_access  output  1  selects data memory (1) or register file (0).
REQ-011 tx  output  1  UART 8N1 serial out, idle high.
REQ-012 busy  output  1  high from dump acceptance until the last stop bit ends.
REQ-013 done  output  1  one-cycle pulse after the last stop bit of a dump.

Function
REQ-014 A dump SHALL start when busy=0 and either stopped rises (registered 0 then 1) or dump_req=1.
REQ-015 Triggers while busy=1 SHALL be ignored; a stopped rise during a dump SHALL NOT queue a second dump.
REQ-016 Entry order SHALL be RF 0..3 (is_dm_access=0, read_addr=0..3), then DM 0..15 (is_dm_access=1, read_addr=0..15): 20 entries.
REQ-017 FSM states SHALL be IDLE, SETUP, SETTLE, CAPTURE, SEND, NEXT, FINISH.
REQ-018 SETUP drives the entry address.
REQ-019 SETTLE holds the address for exactly SETTLE_CYCLES cycles.
REQ-020 CAPTURE latches read_data into an 8-bit snapshot register.
REQ-021 SEND transmits the byte(s) for the snapshot.
REQ-022 NEXT advances the entry, or moves to FINISH after DM 15.
REQ-023 FINISH sends the trailer (if any), pulses done, and returns to IDLE.
REQ-024 read_addr and is_dm_access SHALL stay stable from SETUP through CAPTURE.
REQ-025 UART framing SHALL be a start bit (0), 8 data bits LSB first, and a stop bit (1), each CLKS_PER_BIT cycles.
REQ-026 Consecutive frames SHALL be back-to-back, with no idle bits between them.
REQ-027 tx SHALL change only at bit boundaries.
REQ-028 The first start bit SHALL begin no later than SETTLE_CYCLES+3 cycles after trigger acceptance.
REQ-029 Raw mode (see Configuration) SHALL send header 0xA5, then the 20 snapshot bytes: 21 frames.
REQ-030 Deassertion of stopped mid-dump SHALL NOT abort the dump; each entry reflects read_data at its own CAPTURE cycle.
REQ-031 Trigger acceptance and done SHALL never coincide, so a new dump cannot start in the same cycle done pulses.

Reset
REQ-032 rst_n=0 SHALL immediately force: tx=1, busy=0, done=0, read_addr=0, is_dm_access=0, FSM=IDLE, bit and baud counters=0, stopped-edge register=0.
REQ-033 Reset mid-frame SHALL abandon the dump with tx high at once; no partial frame SHALL resume after release.
REQ-034 After rst_n release with stopped already 1, no dump SHALL start until a new rising edge of stopped or dump_req.

Configuration
REQ-035 Macro DUMP_ASCII_HEX_EN SHALL select the output format.
REQ-036 With the macro defined, each entry SHALL be sent as two uppercase ASCII hex characters (high nibble first) followed by 0x20.
REQ-037 In ASCII mode, the trailer 0x0D 0x0A SHALL follow DM 15, there is no header, and the dump is 62 frames.
REQ-038 With the macro undefined, the raw format of REQ-029 SHALL apply.

Verification (CLKS_PER_BIT=4, SETTLE_CYCLES=2)
REQ-039 Raw mode, stopped 0->1, RF={11,22,33,44}, DM[i]=i: decoded bytes SHALL be A5 11 22 33 44 00 01 ... 0F; done SHALL pulse once, 21*40=840 bit-cycles after the first start bit.
REQ-040 ASCII mode, same data: the stream SHALL be "11 22 33 44 00 01 ... 0F \r\n" (62 bytes); DM value 0xAB SHALL appear as 0x41 0x42 0x20.
REQ-041 dump_req held high through a dump: exactly one new dump SHALL start after done (busy low for at least 1 cycle), and stopped toggling mid-dump SHALL add no extra dump.
REQ-042 Each entry SHALL show read_addr/is_dm_access stable for at least 3 cycles before capture; a bench returning addr-dependent data SHALL see no mismatches.
REQ-043 rst_n pulsed low mid-frame in the 5th byte: tx SHALL go high within the same cycle, busy=0, and no further frames SHALL appear until a new trigger.
REQ-044 With stopped held 1 through reset release: no tx activity for 2000 cycles; then dump_req=1 for 1 cycle SHALL produce a full dump.

Source files
------------

// File: rtl/debug_dump_uart.sv
// Debug dump engine: on CPU halt or a manual request, reads RF[0..3] and DM[0..15] and streams them out as UART 8N1.
// Build option: define DUMP_ASCII_HEX_EN for ASCII hex output; otherwise raw bytes preceded by a 0xA5 header.
module debug_dump_uart #(
    parameter int CLKS_PER_BIT  = 868,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stopped,
    input  logic       dump_req,
    input  logic [7:0] read_data,
    output logic [3:0] read_addr,
    output logic       is_dm_access,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [4:0]        LAST_ENTRY  = 5'd19;
`ifdef DUMP_ASCII_HEX_EN
    localparam logic [1:0]        SEND_LAST   = 2'd2;
`else
    localparam logic [1:0]        SEND_LAST   = 2'd0;
`endif

    typedef enum logic [2:0] {IDLE, SETUP, SETTLE, CAPTURE, SEND, NEXT, FINISH} state_t;

    state_t            r_state;
    logic              r_stopped_d;
    logic              r_edge_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_is_dm;
    logic [3:0]        r_read_addr;
    logic [4:0]        r_entry;
    logic [SET_W-1:0]  r_settle_cnt;
    logic [7:0]        r_snap;
    logic [1:0]        r_char_idx;
    logic              r_tx;
    logic              r_tx_active;
    logic [8:0]        r_shift;
    logic [3:0]        r_bit_cnt;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [7:0]        r_hold;
    logic              r_hold_valid;

    logic       w_stopped_rise;
    logic       w_trigger;
    logic       w_push;
    logic [7:0] w_push_byte;
    logic       w_last_tick;
    logic       w_uart_free;
    logic       w_load_hold;
    logic       w_load_push;
    logic       w_to_hold;
    logic       w_drained;

    function automatic logic [3:0] f_addr(input logic [4:0] entry);
        logic [4:0] t;
        t = (entry < 5'd4) ? entry : entry - 5'd4;
        return t[3:0];
    endfunction

`ifdef DUMP_ASCII_HEX_EN
    function automatic logic [7:0] f_hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction
`endif

    assign read_addr    = r_read_addr;
    assign is_dm_access = r_is_dm;
    assign tx           = r_tx;
    assign busy         = r_busy;
    assign done         = r_done;

    // The edge detector is only armed one cycle after reset, so a stopped already high at release is not a rise.
    assign w_stopped_rise = stopped && !r_stopped_d && r_edge_valid;
    assign w_trigger      = (r_state == IDLE) && !r_done && (w_stopped_rise || dump_req);

    always_comb begin
        w_push      = 1'b0;
        w_push_byte = 8'h00;
        case (r_state)
`ifdef DUMP_ASCII_HEX_EN
            SEND: begin
                if (!r_hold_valid) begin
                    w_push = 1'b1;
                    case (r_char_idx)
                        2'd0:    w_push_byte = f_hex(r_snap[7:4]);
                        2'd1:    w_push_byte = f_hex(r_snap[3:0]);
                        default: w_push_byte = 8'h20;
                    endcase
                end
            end
            FINISH: begin
                if (!r_hold_valid && r_char_idx != 2'd2) begin
                    w_push      = 1'b1;
                    w_push_byte = (r_char_idx == 2'd0) ? 8'h0D : 8'h0A;
                end
            end
`else
            IDLE: begin
                if (w_trigger) begin
                    w_push      = 1'b1;
                    w_push_byte = 8'hA5;
                end
            end
            SEND: begin
                if (!r_hold_valid) begin
                    w_push      = 1'b1;
                    w_push_byte = r_snap;
                end
            end
`endif
            default: ;
        endcase
    end

    // A one-byte holding register lets the next frame start on the very cycle the previous stop bit ends.
    assign w_last_tick = r_tx_active && (r_baud_cnt == BAUD_LAST) && (r_bit_cnt == 4'd9);
    assign w_uart_free = !r_tx_active || w_last_tick;
    assign w_load_hold = w_uart_free && r_hold_valid;
    assign w_load_push = w_uart_free && !r_hold_valid && w_push;
    assign w_to_hold   = w_push && !w_load_push;
    assign w_drained   = !r_hold_valid && (w_last_tick || !r_tx_active);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx         <= 1'b1;
            r_tx_active  <= 1'b0;
            r_shift      <= 9'h1FF;
            r_bit_cnt    <= 4'd0;
            r_baud_cnt   <= '0;
            r_hold       <= 8'h00;
            r_hold_valid <= 1'b0;
        end else begin
            if (w_load_hold || w_load_push) begin
                r_tx_active <= 1'b1;
                r_tx        <= 1'b0;
                r_shift     <= {1'b1, (w_load_hold ? r_hold : w_push_byte)};
                r_bit_cnt   <= 4'd0;
                r_baud_cnt  <= '0;
            end else if (r_tx_active) begin
                if (r_baud_cnt == BAUD_LAST) begin
                    r_baud_cnt <= '0;
                    if (r_bit_cnt == 4'd9) begin
                        r_tx_active <= 1'b0;
                        r_tx        <= 1'b1;
                    end else begin
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b1, r_shift[8:1]};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end else begin
                    r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                end
            end
            if (w_load_hold) begin
                r_hold_valid <= 1'b0;
            end else if (w_to_hold) begin
                r_hold_valid <= 1'b1;
                r_hold       <= w_push_byte;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_stopped_d  <= 1'b0;
            r_edge_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_is_dm      <= 1'b0;
            r_read_addr  <= 4'd0;
            r_entry      <= 5'd0;
            r_settle_cnt <= '0;
            r_snap       <= 8'h00;
            r_char_idx   <= 2'd0;
        end else begin
            r_stopped_d  <= stopped;
            r_edge_valid <= 1'b1;
            r_done       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_busy      <= 1'b1;
                        r_entry     <= 5'd0;
                        r_read_addr <= 4'd0;
                        r_is_dm     <= 1'b0;
                        r_char_idx  <= 2'd0;
                        r_state     <= SETUP;
                    end
                end
                SETUP: begin
                    r_read_addr  <= f_addr(r_entry);
                    r_is_dm      <= (r_entry >= 5'd4);
                    r_settle_cnt <= '0;
                    r_state      <= SETTLE;
                end
                SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_state <= CAPTURE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SET_W'(1);
                    end
                end
                CAPTURE: begin
                    r_snap     <= read_data;
                    r_char_idx <= 2'd0;
                    r_state    <= SEND;
                end
                SEND: begin
                    if (!r_hold_valid) begin
                        if (r_char_idx == SEND_LAST) begin
                            r_char_idx <= 2'd0;
                            r_state    <= NEXT;
                        end else begin
                            r_char_idx <= r_char_idx + 2'd1;
                        end
                    end
                end
                NEXT: begin
                    if (r_entry == LAST_ENTRY) begin
                        r_char_idx <= 2'd0;
                        r_state    <= FINISH;
                    end else begin
                        r_entry     <= r_entry + 5'd1;
                        r_read_addr <= f_addr(r_entry + 5'd1);
                        r_is_dm     <= ((r_entry + 5'd1) >= 5'd4);
                        r_state     <= SETUP;
                    end
                end
                FINISH: begin
`ifdef DUMP_ASCII_HEX_EN
                    if (w_push) begin
                        r_char_idx <= r_char_idx + 2'd1;
                    end else if (r_char_idx == 2'd2 && w_drained) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
`else
                    if (w_drained) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_debug_dump_uart.sv
// Self-checking bench for debug_dump_uart: decodes tx and compares against a stream built from the bench's memory image.
// Follows DUMP_ASCII_HEX_EN the same way as the design.
module tb_debug_dump_uart;
    localparam int CPB    = 4;
    localparam int SETTLE = 2;
    localparam int FRAME  = 10 * CPB;
`ifdef DUMP_ASCII_HEX_EN
    localparam int NFRAMES = 62;
`else
    localparam int NFRAMES = 21;
`endif

    typedef struct {
        int         trig;
        int         pat;
        logic [7:0] expFirst;
        int         probeIdx;
        logic [7:0] probeVal;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stopped = 1'b0;
    logic       dump_req = 1'b0;
    logic [7:0] read_data;
    logic [3:0] read_addr;
    logic       is_dm_access;
    logic       tx;
    logic       busy;
    logic       done;

    logic [7:0] rf [4];
    logic [7:0] dm [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debug_dump_uart #(.CLKS_PER_BIT(CPB), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .stopped(stopped), .dump_req(dump_req),
        .read_data(read_data), .read_addr(read_addr), .is_dm_access(is_dm_access),
        .tx(tx), .busy(busy), .done(done)
    );

    assign read_data = is_dm_access ? dm[read_addr] :
                       ((read_addr < 4'd4) ? rf[read_addr[1:0]] : 8'hEE);

    int cyc = 0;
    always @(posedge clk) cyc++;

    // UART decoder sampling mid-bit on the falling edge.
    int         rxState = 0;
    int         rxCnt = 0;
    logic [7:0] rxShift = 8'h00;
    logic [7:0] rxBytes [$];
    int         rxStarts [$];
    int         framingErrs = 0;
    int         txLowCnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            rxState = 0;
        end else begin
            if (tx == 1'b0) txLowCnt++;
            if (rxState == 0) begin
                if (tx == 1'b0) begin
                    rxState = 1;
                    rxCnt = 0;
                    rxStarts.push_back(cyc);
                end
            end else begin
                rxCnt++;
                if (rxCnt == CPB / 2 && tx !== 1'b0) framingErrs++;
                if (rxCnt >= CPB + CPB / 2 && rxCnt < 9 * CPB && ((rxCnt - CPB / 2) % CPB) == 0)
                    rxShift = {tx, rxShift[7:1]};
                if (rxCnt == 9 * CPB + CPB / 2) begin
                    if (tx !== 1'b1) framingErrs++;
                    rxBytes.push_back(rxShift);
                    rxState = 0;
                end
            end
        end
    end

    logic prevBusy = 1'b0;
    logic prevDone = 1'b0;
    int   starts = 0, busyRiseCyc = 0, busyFallCyc = 0, lastGap = 0;
    int   doneCount = 0, doneCyc = 0, longDone = 0;
    always @(negedge clk) begin
        if (busy && !prevBusy) begin
            starts++;
            busyRiseCyc = cyc;
            lastGap = cyc - busyFallCyc;
        end
        if (!busy && prevBusy) busyFallCyc = cyc;
        if (done && !prevDone) begin
            doneCount++;
            doneCyc = cyc;
        end
        if (done && prevDone) longDone++;
        prevBusy = busy;
        prevDone = done;
    end

    int addrSeq [$];
    int lastKey = -1;
    int runLen = 0;
    int minRun = 1000;
    int addrKey;
    always @(negedge clk) begin
        if (busy) begin
            addrKey = int'({is_dm_access, read_addr});
            if (addrKey != lastKey) begin
                if (lastKey >= 0 && runLen < minRun) minRun = runLen;
                addrSeq.push_back(addrKey);
                lastKey = addrKey;
                runLen = 1;
            end else begin
                runLen++;
            end
        end else begin
            lastKey = -1;
            runLen = 0;
        end
    end

    logic [7:0] expQ [$];

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
    endfunction

    task automatic buildExpected();
        logic [7:0] v;
        expQ.delete();
`ifndef DUMP_ASCII_HEX_EN
        expQ.push_back(8'hA5);
`endif
        for (int e = 0; e < 20; e++) begin
            v = (e < 4) ? rf[e] : dm[e - 4];
`ifdef DUMP_ASCII_HEX_EN
            expQ.push_back(hexc(v[7:4]));
            expQ.push_back(hexc(v[3:0]));
            expQ.push_back(8'h20);
`else
            expQ.push_back(v);
`endif
        end
`ifdef DUMP_ASCII_HEX_EN
        expQ.push_back(8'h0D);
        expQ.push_back(8'h0A);
`endif
    endtask

    task automatic fillPattern(input int pat);
        for (int i = 0; i < 4; i++) begin
            case (pat)
                0:       rf[i] = 8'((i + 1) * 17);
                2:       rf[i] = 8'hFF;
                default: rf[i] = 8'($urandom_range(0, 255));
            endcase
        end
        for (int i = 0; i < 16; i++) begin
            case (pat)
                0:       dm[i] = 8'(i);
                2:       dm[i] = 8'hFF;
                default: dm[i] = 8'($urandom_range(0, 255));
            endcase
        end
        if (pat == 1 || pat == 4) rf[0] = 8'h3D;
        if (pat == 3) begin
            rf[0] = 8'h5C;
            dm[0] = 8'hAB;
        end
    endtask

    task automatic clearMonitors();
        rxBytes.delete();
        rxStarts.delete();
        addrSeq.delete();
        framingErrs = 0;
        minRun = 1000;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitDone(input int base, input int budget);
        int k = 0;
        while (doneCount == base && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput("doneArrived", (doneCount > base) ? 1 : 0, 1);
    endtask

    task automatic applyStimulus(input int trig);
        @(negedge clk);
        if (trig == 0) begin
            stopped = 1'b1;
        end else begin
            dump_req = 1'b1;
            @(negedge clk);
            dump_req = 1'b0;
        end
    endtask

    task automatic checkDump(input vec_t v);
        int bad = 0;
        int gapBad = 0;
        int seqBad = 0;
        int first = -1;
        int probe = -1;
        int t0 = -1;
        checkOutput("frameCount", rxBytes.size(), NFRAMES);
        if (rxBytes.size() > 0) first = int'(rxBytes[0]);
        checkOutput("firstByte", first, int'(v.expFirst));
        if (rxBytes.size() > v.probeIdx) probe = int'(rxBytes[v.probeIdx]);
        checkOutput("probeByte", probe, int'(v.probeVal));
        for (int i = 0; i < rxBytes.size() && i < expQ.size(); i++)
            if (rxBytes[i] != expQ[i]) bad++;
        checkOutput("streamMismatches", bad, 0);
        for (int i = 1; i < rxStarts.size(); i++)
            if (rxStarts[i] - rxStarts[i - 1] != FRAME) gapBad++;
        checkOutput("backToBack", gapBad, 0);
        checkOutput("framingErrors", framingErrs, 0);
        if (rxStarts.size() > 0) t0 = rxStarts[0];
        checkOutput("doneTiming", doneCyc - t0, NFRAMES * FRAME);
        checkOutput("startLatencyOk", (t0 >= busyRiseCyc && t0 - busyRiseCyc <= SETTLE + 3) ? 1 : 0, 1);
        checkOutput("addrSeqLen", addrSeq.size(), 20);
        for (int e = 0; e < addrSeq.size() && e < 20; e++)
            if (addrSeq[e] != ((e < 4) ? e : e + 12)) seqBad++;
        checkOutput("addrSeqOrder", seqBad, 0);
        checkOutput("addrStableOk", (minRun >= SETTLE + 1) ? 1 : 0, 1);
        checkOutput("doneWidth", longDone, 0);
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs [5];
        int   baseDone, baseStarts, snapLow, snapStarts, snapSize, snapDone, bad, k;
`ifdef DUMP_ASCII_HEX_EN
        vecs[0] = '{0, 0, 8'h31, 61, 8'h0A};
        vecs[1] = '{1, 1, 8'h33, 1, 8'h44};
        vecs[2] = '{1, 2, 8'h46, 59, 8'h20};
        vecs[3] = '{0, 3, 8'h35, 12, 8'h41};
        vecs[4] = '{0, 4, 8'h33, 0, 8'h33};
`else
        vecs[0] = '{0, 0, 8'hA5, 20, 8'h0F};
        vecs[1] = '{1, 1, 8'hA5, 1, 8'h3D};
        vecs[2] = '{1, 2, 8'hA5, 13, 8'hFF};
        vecs[3] = '{0, 3, 8'hA5, 5, 8'hAB};
        vecs[4] = '{0, 4, 8'hA5, 1, 8'h3D};
`endif
        fillPattern(0);

        waitCycles(3);
        checkOutput("resetTx", int'(tx), 1);
        checkOutput("resetBusy", int'(busy), 0);
        checkOutput("resetDone", int'(done), 0);
        checkOutput("resetAddr", int'(read_addr), 0);
        checkOutput("resetDm", int'(is_dm_access), 0);
        rst_n = 1'b1;
        waitCycles(20);
        checkOutput("idleNoDump", starts, 0);

        for (int v = 0; v < 5; v++) begin
            fillPattern(vecs[v].pat);
            buildExpected();
            clearMonitors();
            baseDone = doneCount;
            baseStarts = starts;
            applyStimulus(vecs[v].trig);
            if (vecs[v].trig == 0) begin
                waitCycles(150);
                stopped = 1'b0;
                waitCycles(60);
                stopped = 1'b1;
                waitCycles(60);
                stopped = 1'b0;
            end
            waitDone(baseDone, 6000);
            waitCycles(100);
            checkOutput("doneCount", doneCount - baseDone, 1);
            checkOutput("dumpStarts", starts - baseStarts, 1);
            checkDump(vecs[v]);
        end

        $display("[TB] dump_req held through a dump");
        fillPattern(0);
        buildExpected();
        clearMonitors();
        baseDone = doneCount;
        baseStarts = starts;
        @(negedge clk);
        dump_req = 1'b1;
        waitDone(baseDone, 6000);
        k = 0;
        while (starts - baseStarts < 2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        checkOutput("reqHeldRestart", starts - baseStarts, 2);
        checkOutput("busyGapOk", (lastGap >= 1) ? 1 : 0, 1);
        waitCycles(20);
        dump_req = 1'b0;
        waitDone(baseDone + 1, 6000);
        waitCycles(150);
        checkOutput("reqHeldDumps", starts - baseStarts, 2);
        checkOutput("reqHeldFrames", rxBytes.size(), 2 * NFRAMES);
        bad = 0;
        for (int i = 0; i < rxBytes.size() && i < 2 * NFRAMES; i++)
            if (rxBytes[i] != expQ[i % NFRAMES]) bad++;
        checkOutput("reqHeldStream", bad, 0);

        $display("[TB] reset pulse inside the fifth frame");
        fillPattern(1);
        buildExpected();
        clearMonitors();
        baseDone = doneCount;
        applyStimulus(1);
        k = 0;
        while (rxBytes.size() < 4 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        checkOutput("rstFourBytes", (rxBytes.size() >= 4) ? 1 : 0, 1);
        waitCycles(12);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("rstTxHigh", int'(tx), 1);
        checkOutput("rstBusyLow", int'(busy), 0);
        checkOutput("rstDoneLow", int'(done), 0);
        checkOutput("rstAddrZero", int'({is_dm_access, read_addr}), 0);
        waitCycles(3);
        rst_n = 1'b1;
        snapLow = txLowCnt;
        snapStarts = starts;
        snapSize = rxBytes.size();
        waitCycles(400);
        checkOutput("rstNoTxAfter", txLowCnt - snapLow, 0);
        checkOutput("rstNoRestart", starts - snapStarts, 0);
        checkOutput("rstNoMoreBytes", rxBytes.size() - snapSize, 0);
        checkOutput("rstNoDone", doneCount - baseDone, 0);
        bad = 0;
        for (int i = 0; i < 4 && i < rxBytes.size(); i++)
            if (rxBytes[i] != expQ[i]) bad++;
        checkOutput("rstPartialBytes", bad, 0);

        $display("[TB] stopped held high through reset release");
        @(negedge clk);
        rst_n = 1'b0;
        stopped = 1'b1;
        waitCycles(3);
        rst_n = 1'b1;
        snapLow = txLowCnt;
        snapStarts = starts;
        snapDone = doneCount;
        waitCycles(2000);
        checkOutput("heldNoTx", txLowCnt - snapLow, 0);
        checkOutput("heldNoStart", starts - snapStarts, 0);
        fillPattern(0);
        buildExpected();
        clearMonitors();
        applyStimulus(1);
        waitDone(snapDone, 6000);
        waitCycles(50);
        checkOutput("heldOneDump", starts - snapStarts, 1);
        checkDump(vecs[0]);
        stopped = 1'b0;
        waitCycles(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
